nibble_out_port: RTL and testbench

// - Consumer side of the accumulator: drains A values written by OUT instructions to external 4-bit peripherals.
// - Control unit pulses notWrOut; {portAddr, dataIn} is queued in a small FIFO.
// - An FSM replays queued writes onto the peripheral bus with setup/strobe/hold timing and a ready handshake.

---
 rtl/nibbler_pkg.sv | 16 +
 rtl/nibble_fifo.sv | 61 ++++++
 rtl/nibble_out_port.sv | 127 ++++++++++++
 tb/tb_nibble_out_port.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared types and default sizing for the Nibbler output port path.
package nibbler_pkg;

    typedef logic [3:0] nibble_t;

    typedef struct packed {
        nibble_t addr;
        nibble_t data;
    } out_req_t;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} out_state_e;

    localparam int unsigned DefaultDepth        = 4;
    localparam int unsigned DefaultStrobeCycles = 2;

endpackage

// File: rtl/nibble_fifo.sv
// Small request FIFO for queued OUT writes; a push into a full FIFO is accepted when a pop
// happens at the same edge.
module nibble_fifo
    import nibbler_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic     clk,
    input  logic     notReset,
    input  logic     push,
    input  out_req_t wrData,
    input  logic     pop,
    output out_req_t rdData,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    out_req_t        mem [DEPTH];
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic [CntW-1:0] count;
    logic            doPush;
    logic            doPop;

    assign full   = (count == CntW'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!notReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nibble_out_port.sv
// Queues OUT writes and replays them onto a 4-bit peripheral bus with setup/strobe/hold timing.
// Define NIBBLE_OUT_SHADOW_EN to add a readable shadow copy of the last value written per port.
module nibble_out_port
    import nibbler_pkg::*;
#(
    parameter int unsigned DEPTH         = DefaultDepth,
    parameter int unsigned STROBE_CYCLES = DefaultStrobeCycles,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DATA_W        = 4
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [ADDR_W-1:0] portAddr,
    input  logic              notWrOut,
    output logic [ADDR_W-1:0] portAddrOut,
    output logic [DATA_W-1:0] portDataOut,
    output logic              notPortWe,
    input  logic              periphReady,
    output logic              fifoFull,
    output logic              fifoEmpty,
    output logic              overflow,
    output logic              busy
`ifdef NIBBLE_OUT_SHADOW_EN
    ,
    input  logic [ADDR_W-1:0] shadowAddr,
    output logic [DATA_W-1:0] shadowData
`endif
);

    localparam int unsigned CntW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    out_state_e      state;
    logic [CntW-1:0] strobeCnt;
    out_req_t        pushReq;
    out_req_t        head;
    logic            push;
    logic            pop;
    logic            accepted;

    assign pushReq.addr = portAddr;
    assign pushReq.data = dataIn;
    assign push         = !notWrOut;
    assign pop          = (state == IDLE) && !fifoEmpty;
    assign accepted     = push && (!fifoFull || pop);
    assign busy         = (state != IDLE) || !fifoEmpty;

    nibble_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .notReset (notReset),
        .push     (push),
        .wrData   (pushReq),
        .pop      (pop),
        .rdData   (head),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (!notReset) begin
            state       <= IDLE;
            portAddrOut <= '0;
            portDataOut <= '0;
            notPortWe   <= 1'b1;
            strobeCnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifoEmpty) begin
                        portAddrOut <= head.addr;
                        portDataOut <= head.data;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (periphReady) begin
                        notPortWe <= 1'b0;
                        strobeCnt <= CntW'(STROBE_CYCLES - 1);
                        state     <= STROBE;
                    end
                end
                STROBE: begin
                    if (strobeCnt == '0) begin
                        notPortWe <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        strobeCnt <= strobeCnt - 1'b1;
                    end
                end
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky until reset: a request arrived with no room and no simultaneous pop.
    always_ff @(posedge clk) begin
        if (!notReset) begin
            overflow <= 1'b0;
        end else if (push && fifoFull && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef NIBBLE_OUT_SHADOW_EN
    logic [DATA_W-1:0] shadow [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (!notReset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                shadow[i] <= '0;
            end
        end else if (accepted) begin
            shadow[portAddr] <= dataIn;
        end
    end

    assign shadowData = shadow[shadowAddr];
`else
    // No shadow storage; accepted is only consumed by the shadow array.
    logic unusedAccepted;
    assign unusedAccepted = accepted;
`endif

endmodule

// File: tb/tb_nibble_out_port.sv
// Directed self-checking bench for nibble_out_port (DEPTH=4, STROBE_CYCLES=2).
module tb_nibble_out_port;

    logic       clk = 1'b0;
    logic       notReset;
    logic [3:0] dataIn;
    logic [3:0] portAddr;
    logic       notWrOut;
    logic [3:0] portAddrOut;
    logic [3:0] portDataOut;
    logic       notPortWe;
    logic       periphReady;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       overflow;
    logic       busy;
`ifdef NIBBLE_OUT_SHADOW_EN
    logic [3:0] shadowAddr;
    logic [3:0] shadowData;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] gotData[$];
    int         gotLen[$];
    logic       prevWe = 1'b1;
    int         lowCnt = 0;

    always #5 clk = ~clk;

    nibble_out_port #(
        .DEPTH         (4),
        .STROBE_CYCLES (2),
        .ADDR_W        (4),
        .DATA_W        (4)
    ) dut (
        .clk         (clk),
        .notReset    (notReset),
        .dataIn      (dataIn),
        .portAddr    (portAddr),
        .notWrOut    (notWrOut),
        .portAddrOut (portAddrOut),
        .portDataOut (portDataOut),
        .notPortWe   (notPortWe),
        .periphReady (periphReady),
        .fifoFull    (fifoFull),
        .fifoEmpty   (fifoEmpty),
        .overflow    (overflow),
        .busy        (busy)
`ifdef NIBBLE_OUT_SHADOW_EN
        ,
        .shadowAddr  (shadowAddr),
        .shadowData  (shadowData)
`endif
    );

    // Strobe monitor: logs bus value at each falling strobe and the strobe length on rise.
    always @(negedge clk) begin
        if (prevWe === 1'b1 && notPortWe === 1'b0) begin
            gotData.push_back({portAddrOut, portDataOut});
            lowCnt = 1;
        end else if (notPortWe === 1'b0) begin
            lowCnt++;
        end else if (prevWe === 1'b0 && notPortWe === 1'b1) begin
            gotLen.push_back(lowCnt);
        end
        prevWe = notPortWe;
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitWe(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (notPortWe !== lvl && n < bound) begin
            tick();
            n++;
        end
        checkEq(tag, {31'd0, notPortWe}, {31'd0, lvl});
    endtask

    task automatic waitIdle(input int bound, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        checkEq(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        notReset    = 1'b0;
        notWrOut    = 1'b1;
        periphReady = 1'b1;
        dataIn      = 4'h0;
        portAddr    = 4'h0;
`ifdef NIBBLE_OUT_SHADOW_EN
        shadowAddr  = 4'h0;
`endif
        tick();
        tick();
        checkEq("rst_full", {31'd0, fifoFull}, 32'd0);
        checkEq("rst_ovf", {31'd0, overflow}, 32'd0);
        notReset = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            checkEq("idle_we", {31'd0, notPortWe}, 32'd1);
            checkEq("idle_bus", {24'd0, portAddrOut, portDataOut}, 32'h00);
            checkEq("idle_empty", {31'd0, fifoEmpty}, 32'd1);
            checkEq("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Single write latency
        gotData.delete();
        gotLen.delete();
        portAddr = 4'h3;
        dataIn   = 4'hA;
        notWrOut = 1'b0;
        tick();
        notWrOut = 1'b1;
        checkEq("e0_empty", {31'd0, fifoEmpty}, 32'd0);
        checkEq("e0_we", {31'd0, notPortWe}, 32'd1);
        tick();
        checkEq("e1_bus", {24'd0, portAddrOut, portDataOut}, 32'h3A);
        checkEq("e1_we", {31'd0, notPortWe}, 32'd1);
        tick();
        checkEq("e2_we", {31'd0, notPortWe}, 32'd0);
        tick();
        checkEq("e3_we", {31'd0, notPortWe}, 32'd0);
        tick();
        checkEq("e4_we", {31'd0, notPortWe}, 32'd1);
        checkEq("e4_bus", {24'd0, portAddrOut, portDataOut}, 32'h3A);
        tick();
        checkEq("e5_busy", {31'd0, busy}, 32'd0);
        checkEq("single_cnt", gotLen.size(), 32'd1);
        if (gotLen.size() > 0) checkEq("single_len", gotLen[0], 32'd2);

        // Peripheral not ready holds SETUP
        periphReady = 1'b0;
        portAddr    = 4'h5;
        dataIn      = 4'h9;
        notWrOut    = 1'b0;
        tick();
        notWrOut = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checkEq("setup_we", {31'd0, notPortWe}, 32'd1);
            checkEq("setup_bus", {24'd0, portAddrOut, portDataOut}, 32'h59);
        end
        periphReady = 1'b1;
        tick();
        checkEq("ready_strobe", {31'd0, notPortWe}, 32'd0);
        waitIdle(20, "ready_idle");

`ifdef NIBBLE_OUT_SHADOW_EN
        shadowAddr = 4'hC;
        #0;
        checkEq("shadow_init", {28'd0, shadowData}, 32'h0);
        portAddr = 4'hC;
        dataIn   = 4'h7;
        notWrOut = 1'b0;
        tick();
        notWrOut = 1'b1;
        checkEq("shadow_write", {28'd0, shadowData}, 32'h7);
        waitIdle(20, "shadow_idle");
`endif

        // Push into a full FIFO while the FSM pops at the same edge
        gotData.delete();
        periphReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            portAddr = 4'h1;
            dataIn   = 4'(i);
            notWrOut = 1'b0;
            tick();
        end
        notWrOut = 1'b1;
        checkEq("fill_full", {31'd0, fifoFull}, 32'd1);
        checkEq("fill_noovf", {31'd0, overflow}, 32'd0);
        periphReady = 1'b1;
        waitWe(1'b0, 10, "fill_lo");
        waitWe(1'b1, 10, "fill_hi");
        tick();
        dataIn   = 4'h6;
        notWrOut = 1'b0;
        tick();
        notWrOut = 1'b1;
        checkEq("fullpop_full", {31'd0, fifoFull}, 32'd1);
        checkEq("fullpop_noovf", {31'd0, overflow}, 32'd0);
        waitIdle(80, "fullpop_idle");
        checkEq("fullpop_cnt", gotData.size(), 32'd6);
        for (int i = 0; i < gotData.size() && i < 6; i++) begin
            checkEq("fullpop_data", {24'd0, gotData[i]}, 32'h10 + 32'(i + 1));
        end

        // Six pushes with peripheral stalled: one dropped
        gotData.delete();
        gotLen.delete();
        periphReady = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            portAddr = (i == 6) ? 4'hC : 4'h8;
            dataIn   = 4'(i);
            notWrOut = 1'b0;
            tick();
        end
        notWrOut = 1'b1;
        checkEq("ovf_flag", {31'd0, overflow}, 32'd1);
        checkEq("ovf_full", {31'd0, fifoFull}, 32'd1);
        checkEq("ovf_busy", {31'd0, busy}, 32'd1);
`ifdef NIBBLE_OUT_SHADOW_EN
        shadowAddr = 4'hC;
        #0;
        checkEq("shadow_drop", {28'd0, shadowData}, 32'h7);
        shadowAddr = 4'h8;
        #0;
        checkEq("shadow_last", {28'd0, shadowData}, 32'h5);
`endif
        periphReady = 1'b1;
        waitIdle(80, "ovf_idle");
        for (int i = 0; i < 5; i++) tick();
        checkEq("ovf_cnt", gotData.size(), 32'd5);
        for (int i = 0; i < gotData.size() && i < 5; i++) begin
            checkEq("ovf_data", {24'd0, gotData[i]}, 32'h80 + 32'(i + 1));
            if (i < gotLen.size()) checkEq("ovf_len", gotLen[i], 32'd2);
        end
        checkEq("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset mid-strobe
        gotData.delete();
        portAddr = 4'h2;
        dataIn   = 4'h7;
        notWrOut = 1'b0;
        tick();
        notWrOut = 1'b1;
        tick();
        tick();
        checkEq("mid_we", {31'd0, notPortWe}, 32'd0);
        notReset = 1'b0;
        tick();
        checkEq("cut_we", {31'd0, notPortWe}, 32'd1);
        checkEq("cut_bus", {24'd0, portAddrOut, portDataOut}, 32'h00);
        checkEq("cut_empty", {31'd0, fifoEmpty}, 32'd1);
        checkEq("cut_busy", {31'd0, busy}, 32'd0);
        checkEq("cut_ovf", {31'd0, overflow}, 32'd0);
`ifdef NIBBLE_OUT_SHADOW_EN
        shadowAddr = 4'hC;
        #0;
        checkEq("shadow_rst", {28'd0, shadowData}, 32'h0);
`endif
        notReset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checkEq("cut_strobes", gotData.size(), 32'd1);
        checkEq("cut_final_we", {31'd0, notPortWe}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
